pick_ctrl: RTL and testbench

PICK_CTRL -- requirements
Module: pick_ctrl

---
 rtl/pick_pkg.sv | 40 ++++
 rtl/pick_hold_cnt.sv | 24 ++
 rtl/pick_ctrl.sv | 103 ++++++++++
 tb/tb_pick_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pick_pkg.sv
// Shared types for the pick controller: motion codes, FSM states,
// default key constants and the state-to-output decode helpers.
package pick_pkg;

    localparam logic [7:0] KEY_UP_DEF = 8'h1A;  // W
    localparam logic [7:0] KEY_DN_DEF = 8'h16;  // S
    localparam int         CNT_W      = 6;

    // Motion command sent to the pick mover; 101-111 are never produced.
    typedef enum logic [2:0] {
        DIR_HOLD = 3'b000,
        DIR_UP1  = 3'b001,
        DIR_DN1  = 3'b010,
        DIR_DN2  = 3'b011,
        DIR_UP2  = 3'b100
    } dir_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_SLOW = 3'd1,
        DN_SLOW = 3'd2,
        UP_FAST = 3'd3,
        DN_FAST = 3'd4
    } state_t;

    function automatic dir_t dir_of(input state_t s);
        case (s)
            UP_SLOW: dir_of = DIR_UP1;
            DN_SLOW: dir_of = DIR_DN1;
            UP_FAST: dir_of = DIR_UP2;
            DN_FAST: dir_of = DIR_DN2;
            default: dir_of = DIR_HOLD;
        endcase
    endfunction

    function automatic logic fast_of(input state_t s);
        fast_of = (s == UP_FAST) || (s == DN_FAST);
    endfunction

endpackage

// File: rtl/pick_hold_cnt.sv
// Saturating 6-bit hold counter: counts consecutive held frames while
// the controller sits in a SLOW state. clr has priority over inc.
module pick_hold_cnt
    import pick_pkg::*;
(
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear, or step up once per frame and stick at all-ones.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pick_ctrl.sv
// Keyboard-driven pick motion controller. One frame of latency from the
// sampled keycode to dir. Fast mode (2-step moves after HOLD_FRAMES held
// frames) exists only when PICK_CTRL_FAST_EN is defined; otherwise the
// FAST states and hold counter are not built and fast is tied low.
module pick_ctrl
    import pick_pkg::*;
#(
    parameter logic [7:0] KEY_UP      = KEY_UP_DEF,
    parameter logic [7:0] KEY_DN      = KEY_DN_DEF,
    parameter int         HOLD_FRAMES = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [2:0] dir,
    output logic       fast
);

    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 63) begin : g_bad_hold
        $error("pick_ctrl: HOLD_FRAMES out of range 1..63");
    end

    state_t state;
    state_t state_nxt;

    wire key_up = (keycode == KEY_UP);
    wire key_dn = (keycode == KEY_DN);

`ifdef PICK_CTRL_FAST_EN
    logic [CNT_W-1:0] hold_count;
    logic             hold_inc;
    logic             hold_last;

    // Count only while the same direction stays held in its SLOW state.
    assign hold_inc  = (key_up && state == UP_SLOW) || (key_dn && state == DN_SLOW);
    assign hold_last = (hold_count == CNT_W'(HOLD_FRAMES - 1));

    pick_hold_cnt u_hold_cnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (!hold_inc),
        .inc       (hold_inc),
        .count     (hold_count)
    );

    // Next state: a key entering from anywhere else lands in its SLOW state
    // (so reversals skip IDLE); SLOW promotes to FAST on the last hold frame.
    always_comb begin
        state_nxt = IDLE;
        if (key_up) begin
            case (state)
                UP_SLOW: state_nxt = hold_last ? UP_FAST : UP_SLOW;
                UP_FAST: state_nxt = UP_FAST;
                default: state_nxt = UP_SLOW;
            endcase
        end else if (key_dn) begin
            case (state)
                DN_SLOW: state_nxt = hold_last ? DN_FAST : DN_SLOW;
                DN_FAST: state_nxt = DN_FAST;
                default: state_nxt = DN_SLOW;
            endcase
        end
    end

    // State register with outputs decoded from the next state, so dir and
    // fast change on the same edge that samples the key.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            dir   <= DIR_HOLD;
            fast  <= 1'b0;
        end else begin
            state <= state_nxt;
            dir   <= dir_of(state_nxt);
            fast  <= fast_of(state_nxt);
        end
    end
`else
    // Next state without fast mode: only the SLOW states are reachable.
    always_comb begin
        state_nxt = IDLE;
        if (key_up) begin
            state_nxt = UP_SLOW;
        end else if (key_dn) begin
            state_nxt = DN_SLOW;
        end
    end

    // State register with dir decoded from the next state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            dir   <= DIR_HOLD;
        end else begin
            state <= state_nxt;
            dir   <= dir_of(state_nxt);
        end
    end

    assign fast = 1'b0;
`endif

endmodule

// File: tb/tb_pick_ctrl.sv
// Directed, table-driven bench for pick_ctrl. Expected values follow the
// build: with PICK_CTRL_FAST_EN defined the fast codes are expected,
// otherwise dir stays on the slow codes and fast stays low.
module tb_pick_ctrl;

`ifdef PICK_CTRL_FAST_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic [2:0] dir;
    logic       fast;
    logic [2:0] dir1;
    logic       fast1;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] key;
        logic [2:0] dir;
        logic       fast;
    } vec_t;

    vec_t vecs[$];

    // Clock and DUTs
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    pick_ctrl u_dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .dir       (dir),
        .fast      (fast)
    );

    pick_ctrl #(.HOLD_FRAMES(1)) u_dut1 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .dir       (dir1),
        .fast      (fast1)
    );

    task automatic check(input string name, input logic [2:0] act_dir, input logic act_fast,
                         input logic [2:0] exp_dir, input logic exp_fast);
        n_checks++;
        if (act_dir !== exp_dir || act_fast !== exp_fast) begin
            n_fail++;
            $display("FAIL %s: got dir=%b fast=%b, expected dir=%b fast=%b",
                     name, act_dir, act_fast, exp_dir, exp_fast);
        end
    endtask

    task automatic add(input logic [7:0] key, input int n, input logic [2:0] d, input logic f);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.key  = key;
            v.dir  = d;
            v.fast = f;
            vecs.push_back(v);
        end
    endtask

    // Drive a key for one frame and settle just after the sampling edge.
    task automatic frame(input logic [7:0] key);
        keycode = key;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        keycode = 8'h00;
        repeat (2) @(posedge frame_clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        keycode  = 8'h00;

        // Reset state
        #1;
        check("reset_async", dir, fast, 3'b000, 1'b0);
        do_reset();
        check("reset_state", dir, fast, 3'b000, 1'b0);

        // Single tap up, then release
        add(8'h1A, 1, 3'b001, 1'b0);
        add(8'h00, 1, 3'b000, 1'b0);
        // Down held 40 frames: slow for 30, fast afterwards
        add(8'h16, 30, 3'b010, 1'b0);
        add(8'h16, 10, FE ? 3'b011 : 3'b010, FE);
        add(8'h00, 1, 3'b000, 1'b0);
        // Up 20 frames then direct reversal to down: no hold frame,
        // fast only after 30 frames of the new key
        add(8'h1A, 20, 3'b001, 1'b0);
        add(8'h16, 30, 3'b010, 1'b0);
        add(8'h16, 5, FE ? 3'b011 : 3'b010, FE);
        add(8'h00, 1, 3'b000, 1'b0);
        // Reach UP_FAST, then an unrelated key drops to hold
        add(8'h1A, 30, 3'b001, 1'b0);
        add(8'h1A, 2, FE ? 3'b100 : 3'b001, FE);
        add(8'h04, 1, 3'b000, 1'b0);
        // One-frame release restarts qualification
        add(8'h1A, 10, 3'b001, 1'b0);
        add(8'h00, 1, 3'b000, 1'b0);
        add(8'h1A, 30, 3'b001, 1'b0);
        add(8'h1A, 1, FE ? 3'b100 : 3'b001, FE);
        add(8'h00, 1, 3'b000, 1'b0);
        // Long hold: saturating counter must not drop out of fast
        add(8'h1A, 30, 3'b001, 1'b0);
        add(8'h1A, 70, FE ? 3'b100 : 3'b001, FE);
        add(8'h00, 1, 3'b000, 1'b0);

        foreach (vecs[i]) begin
            frame(vecs[i].key);
            check($sformatf("vec%0d_key%02h", i, vecs[i].key), dir, fast, vecs[i].dir, vecs[i].fast);
        end

        // Asynchronous reset mid-hold, between clock edges
        for (int i = 0; i < 35; i++) frame(8'h1A);
        check("pre_reset_hold", dir, fast, FE ? 3'b100 : 3'b001, FE);
        @(negedge frame_clk);
        Reset = 1'b1;
        #1;
        check("reset_mid_run", dir, fast, 3'b000, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;
        // Count discarded: slow for 30 frames again after release
        for (int i = 1; i <= 31; i++) begin
            frame(8'h1A);
            if (i == 1)  check("post_reset_f1", dir, fast, 3'b001, 1'b0);
            if (i == 30) check("post_reset_f30", dir, fast, 3'b001, 1'b0);
            if (i == 31) check("post_reset_f31", dir, fast, FE ? 3'b100 : 3'b001, FE);
        end

        // HOLD_FRAMES = 1: fast on the second held frame
        do_reset();
        check("h1_reset", dir1, fast1, 3'b000, 1'b0);
        frame(8'h16);
        check("h1_f1", dir1, fast1, 3'b010, 1'b0);
        frame(8'h16);
        check("h1_f2", dir1, fast1, FE ? 3'b011 : 3'b010, FE);
        frame(8'h1A);
        check("h1_rev_f1", dir1, fast1, 3'b001, 1'b0);
        frame(8'h1A);
        check("h1_rev_f2", dir1, fast1, FE ? 3'b100 : 3'b001, FE);
        frame(8'h00);
        check("h1_release", dir1, fast1, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
